// File: rtl/csr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csr_pkg : CSR addresses, op encoding, mstatus fields, WARL helpers    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;

  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_wval(csr_op_e op, logic [31:0] old_v, logic [31:0] wd);
    case (op)
      CSR_OP_RW: return wd;
      CSR_OP_RS: return old_v | wd;
      CSR_OP_RC: return old_v & ~wd;
      default:   return old_v;
    endcase
  endfunction

  // Reserved modes 10/11 collapse to direct mode.
  function automatic logic [31:0] mtvec_legalize(logic [31:0] v);
    return {v[31:2], 1'b0, (v[1:0] == 2'b01)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csr_counter64 : 64-bit counter, increment enable, per-half writes     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic [32:0] lo_inc;

  always_comb begin
    lo_inc = {1'b0, lo_q} + 33'd1;
    lo_d   = lo_q;
    hi_d   = hi_q;
    if (inc_i) begin
      lo_d = lo_inc[31:0];
      hi_d = hi_q + {31'b0, lo_inc[32]};
    end
    // A write to one half suppresses the increment; the other half holds.
    if (wr_lo_i) begin
      lo_d = wdata_i;
      hi_d = hi_q;
    end
    if (wr_hi_i) begin
      hi_d = wdata_i;
      lo_d = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign value_o = {hi_q, lo_q};

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | csr_unit : M-mode CSR file and trap/mret sequencer.                   |
// | Optional counters with CSR_COUNTERS_EN.            Rev 1.0            |
// +----------------------------------------------------------------------+
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter logic [31:0] HART_ID       = 32'h0,
  parameter logic [31:0] MTVEC_RESET   = 32'h0,
  parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            instr_retire,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            irq_enable
);

  csr_op_e     op;
  logic        mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mcause_q, mcause_d;
  logic [29:0] mepc_q, mepc_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] mstatus_rd, mepc_rd, rd_raw, wval, trap_base, trap_target;
  logic        implemented, read_only, illegal, csr_we;

  assign op         = csr_op_e'(csr_op);
  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign mepc_rd    = {mepc_q, 2'b00};

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && (csr_addr == CSR_MCYCLE)),
    .wr_hi_i (csr_we && (csr_addr == CSR_MCYCLEH)),
    .wdata_i (wval),
    .value_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (instr_retire),
    .wr_lo_i (csr_we && (csr_addr == CSR_MINSTRET)),
    .wr_hi_i (csr_we && (csr_addr == CSR_MINSTRETH)),
    .wdata_i (wval),
    .value_o (minstret)
  );
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  always_comb begin
    rd_raw      = '0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csr_addr)
      CSR_MSTATUS:  rd_raw = mstatus_rd;
      CSR_MISA:     begin rd_raw = MISA_VAL; read_only = 1'b1; end
      CSR_MTVEC:    rd_raw = mtvec_q;
      CSR_MSCRATCH: rd_raw = mscratch_q;
      CSR_MEPC:     rd_raw = mepc_rd;
      CSR_MCAUSE:   rd_raw = mcause_q;
      CSR_MHARTID:  begin rd_raw = HART_ID; read_only = 1'b1; end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    rd_raw = mcycle[31:0];
      CSR_MCYCLEH:   rd_raw = mcycle[63:32];
      CSR_MINSTRET:  rd_raw = minstret[31:0];
      CSR_MINSTRETH: rd_raw = minstret[63:32];
`endif
      default:      implemented = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read, so it is legal on read-only CSRs.
  assign illegal     = (op != CSR_OP_NONE) &&
                       (!implemented || (read_only && ((op == CSR_OP_RW) || (csr_wdata != '0))));
  assign csr_illegal = illegal;
  assign csr_rdata   = illegal ? '0 : rd_raw;
  assign wval        = csr_wval(op, rd_raw, csr_wdata);
  assign csr_we      = (op != CSR_OP_NONE) && !illegal && !trap_valid && !mret;

  assign trap_base   = {mtvec_q[31:2], 2'b00};
  assign trap_target = (mtvec_q[0] && trap_cause[31]) ? trap_base + {trap_cause[29:0], 2'b00}
                                                      : trap_base;

  always_comb begin
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    if (trap_valid) begin
      mepc_d           = trap_pc[31:2];
      mcause_d         = trap_cause;
      mpie_d           = mie_q;
      mie_d            = 1'b0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = trap_target;
    end else if (mret) begin
      mie_d            = mpie_q;
      mpie_d           = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_rd;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS:  begin mie_d = wval[MSTATUS_MIE]; mpie_d = wval[MSTATUS_MPIE]; end
        CSR_MTVEC:    mtvec_d    = mtvec_legalize(wval);
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval[31:2];
        CSR_MCAUSE:   mcause_d   = wval;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q            <= MSTATUS_RESET[MSTATUS_MIE];
      mpie_q           <= MSTATUS_RESET[MSTATUS_MPIE];
      mtvec_q          <= mtvec_legalize(MTVEC_RESET);
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mie_q            <= mie_d;
      mpie_q           <= mpie_d;
      mtvec_q          <= mtvec_d;
      mscratch_q       <= mscratch_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign irq_enable     = mie_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_csr_unit : scoreboard bench for csr_unit (honours CSR_COUNTERS_EN) |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_csr_unit;

  typedef struct {
    int          cyc;
    int          kind;   // 0: rdata+illegal, 1: irq_enable, 2: redirect_valid level
    string       nm;
    logic [31:0] v;
    logic        ill;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } redir_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, trap_cause, trap_pc, redirect_pc;
  logic        csr_illegal, trap_valid, mret, instr_retire, redirect_valid, irq_enable;

  exp_t   rdq[$];
  redir_t rq[$];
  int     cyc = 0;
  int     n_vec = 0;
  int     n_miss = 0;

  csr_unit #(
    .XLEN          (32),
    .HART_ID       (32'h0000_0005),
    .MTVEC_RESET   (32'h0000_0100),
    .MSTATUS_RESET (32'h0000_1800)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .csr_op         (csr_op),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .trap_valid     (trap_valid),
    .trap_cause     (trap_cause),
    .trap_pc        (trap_pc),
    .mret           (mret),
    .instr_retire   (instr_retire),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq_enable     (irq_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Monitor: compares whatever the DUT presents against queued expectations.
  always @(negedge clk) begin
    exp_t   e;
    redir_t r;
    while (rdq.size() > 0 && rdq[0].cyc <= cyc) begin
      e = rdq.pop_front();
      n_vec++;
      if (e.cyc != cyc) begin
        n_miss++;
        $display("FAIL %s: expectation for cycle %0d checked at cycle %0d", e.nm, e.cyc, cyc);
      end else if (e.kind == 0 && (csr_rdata !== e.v || csr_illegal !== e.ill)) begin
        n_miss++;
        $display("FAIL %s: rdata=%h illegal=%b, want rdata=%h illegal=%b",
                 e.nm, csr_rdata, csr_illegal, e.v, e.ill);
      end else if (e.kind == 1 && irq_enable !== e.v[0]) begin
        n_miss++;
        $display("FAIL %s: irq_enable=%b, want %b", e.nm, irq_enable, e.v[0]);
      end else if (e.kind == 2 && redirect_valid !== e.v[0]) begin
        n_miss++;
        $display("FAIL %s: redirect_valid=%b, want %b", e.nm, redirect_valid, e.v[0]);
      end
    end
    if (redirect_valid === 1'b1) begin
      n_vec++;
      if (rq.size() == 0) begin
        n_miss++;
        $display("FAIL redirect: unexpected pulse pc=%h at cycle %0d", redirect_pc, cyc);
      end else begin
        r = rq.pop_front();
        if (r.cyc != cyc || redirect_pc !== r.pc) begin
          n_miss++;
          $display("FAIL redirect: pc=%h at cycle %0d, want pc=%h at cycle %0d",
                   redirect_pc, cyc, r.pc, r.cyc);
        end
      end
    end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
      r = rq.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL redirect: no pulse at cycle %0d, want pc=%h", cyc, r.pc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic tv, input logic [31:0] cause, input logic [31:0] pc,
                       input logic mr, input logic ret);
    csr_op       = op;
    csr_addr     = addr;
    csr_wdata    = wd;
    trap_valid   = tv;
    trap_cause   = cause;
    trap_pc      = pc;
    mret         = mr;
    instr_retire = ret;
  endtask

  task automatic exp_rd(input string nm, input logic [31:0] v, input logic ill);
    rdq.push_back('{cyc, 0, nm, v, ill});
  endtask

  task automatic exp_lvl(input int kind, input string nm, input logic b);
    rdq.push_back('{cyc, kind, nm, {31'b0, b}, 1'b0});
  endtask

  task automatic exp_redir(input logic [31:0] pc);
    rq.push_back('{cyc + 1, pc});
  endtask

  // One cycle: a CSR access (optionally checked) with no trap/mret.
  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                     input string nm, input logic [31:0] v, input logic ill);
    drive(op, addr, wd, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    exp_rd(nm, v, ill);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    exp_lvl(2, "reset_redirect", 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    csr(2'b00, 12'h300, 32'h0, "rst_mstatus", 32'h0000_1800, 1'b0);
    csr(2'b00, 12'h305, 32'h0, "rst_mtvec", 32'h0000_0100, 1'b0);
    exp_lvl(1, "rst_irq_enable", 1'b0);
    csr(2'b00, 12'hF14, 32'h0, "mhartid", 32'h0000_0005, 1'b0);

    csr(2'b01, 12'h305, 32'h8000_0103, "mtvec_rw_old", 32'h0000_0100, 1'b0);
    csr(2'b00, 12'h305, 32'h0, "mtvec_warl", 32'h8000_0100, 1'b0);
    csr(2'b10, 12'h340, 32'h0000_00F0, "mscratch_rs_old", 32'h0, 1'b0);
    csr(2'b11, 12'h340, 32'h0000_0030, "mscratch_rc_old", 32'h0000_00F0, 1'b0);
    csr(2'b00, 12'h340, 32'h0, "mscratch_rsrc", 32'h0000_00C0, 1'b0);

    csr(2'b10, 12'h300, 32'h0000_0008, "mstatus_set_mie", 32'h0000_1800, 1'b0);
    exp_lvl(1, "irq_on", 1'b1);
    csr(2'b00, 12'h300, 32'h0, "mstatus_mie", 32'h0000_1808, 1'b0);

    // Direct-mode synchronous trap.
    drive(2'b00, 12'h0, 32'h0, 1'b1, 32'd11, 32'h8000_0040, 1'b0, 1'b0);
    exp_redir(32'h8000_0100);
    tick();
    csr(2'b00, 12'h341, 32'h0, "trap_mepc", 32'h8000_0040, 1'b0);
    csr(2'b00, 12'h342, 32'h0, "trap_mcause", 32'd11, 1'b0);
    exp_lvl(1, "trap_irq_off", 1'b0);
    csr(2'b00, 12'h300, 32'h0, "trap_mstatus", 32'h0000_1880, 1'b0);

    // Vectored-mode interrupt, then mret.
    csr(2'b01, 12'h305, 32'h8000_0001, "mtvec_vec_old", 32'h8000_0100, 1'b0);
    csr(2'b10, 12'h300, 32'h0000_0008, "mstatus_set2", 32'h0000_1880, 1'b0);
    drive(2'b00, 12'h0, 32'h0, 1'b1, 32'h8000_0007, 32'h8000_0200, 1'b0, 1'b0);
    exp_redir(32'h8000_001C);
    tick();
    csr(2'b00, 12'h341, 32'h0, "vec_mepc", 32'h8000_0200, 1'b0);
    drive(2'b00, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    exp_redir(32'h8000_0200);
    tick();
    exp_lvl(1, "mret_irq_on", 1'b1);
    csr(2'b00, 12'h300, 32'h0, "mret_mstatus", 32'h0000_1888, 1'b0);

    // Trap + mret + mscratch write together: only the trap lands.
    drive(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b1, 32'd2, 32'h8000_0300, 1'b1, 1'b0);
    exp_rd("prio_rdata", 32'h0000_00C0, 1'b0);
    exp_redir(32'h8000_0000);
    tick();
    csr(2'b00, 12'h340, 32'h0, "prio_mscratch", 32'h0000_00C0, 1'b0);
    csr(2'b00, 12'h341, 32'h0, "prio_mepc", 32'h8000_0300, 1'b0);
    csr(2'b00, 12'h300, 32'h0, "prio_mstatus", 32'h0000_1880, 1'b0);

    csr(2'b01, 12'h301, 32'h0, "misa_write", 32'h0, 1'b1);
    csr(2'b00, 12'h301, 32'h0, "misa_read", 32'h4000_0100, 1'b0);

    // Back-to-back interrupts; the second lands in the first's redirect cycle.
    drive(2'b00, 12'h0, 32'h0, 1'b1, 32'h8000_0003, 32'h0000_0100, 1'b0, 1'b0);
    exp_redir(32'h8000_000C);
    tick();
    drive(2'b00, 12'h0, 32'h0, 1'b1, 32'h8000_0005, 32'h0000_0104, 1'b0, 1'b0);
    exp_redir(32'h8000_0014);
    tick();
    csr(2'b00, 12'h341, 32'h0, "b2b_mepc", 32'h0000_0104, 1'b0);
    csr(2'b00, 12'h300, 32'h0, "b2b_mstatus", 32'h0000_1800, 1'b0);

    csr(2'b01, 12'h341, 32'h8000_0403, "mepc_rw_old", 32'h0000_0104, 1'b0);
    csr(2'b00, 12'h341, 32'h0, "mepc_warl", 32'h8000_0400, 1'b0);

`ifdef CSR_COUNTERS_EN
    drive(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    csr(2'b00, 12'hB00, 32'h0, "mcycle_lo_wr", 32'hFFFF_FFFF, 1'b0);
    csr(2'b00, 12'hB80, 32'h0, "mcycle_hi_carry", 32'h0000_0001, 1'b0);
    drive(2'b01, 12'hB02, 32'h0000_0005, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    csr(2'b00, 12'hB02, 32'h0, "minstret_wr", 32'h0000_0005, 1'b0);
    drive(2'b00, 12'hB02, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    tick();
    csr(2'b00, 12'hB02, 32'h0, "minstret_inc", 32'h0000_0006, 1'b0);
    csr(2'b00, 12'hB82, 32'h0, "minstret_hi", 32'h0, 1'b0);
`else
    csr(2'b10, 12'hB00, 32'h0, "mcycle_absent", 32'h0, 1'b1);
    csr(2'b01, 12'hB82, 32'h1, "minstreth_absent", 32'h0, 1'b1);
`endif

    // Reset during the redirect cycle must drop the pulse at once.
    drive(2'b00, 12'h0, 32'h0, 1'b1, 32'd1, 32'h0, 1'b0, 1'b0);
    tick();
    drive(2'b00, 12'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_lvl(2, "async_reset_pulse", 1'b0);
    tick();
    rst_n = 1'b1;
    csr(2'b00, 12'h300, 32'h0, "post_reset_mstatus", 32'h0000_1800, 1'b0);
    tick();
    tick();

    n_vec++;
    if (rdq.size() != 0 || rq.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d read and %0d redirect expectations left, want 0 and 0",
               rdq.size(), rq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
